// File: rtl/divider_8_4_bit_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module divider_8_4_bit_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accept edge
    // CALC  | eight shift/subtract steps, dividend MSB first
    // DONE  | one-cycle done pulse with results valid, then back to IDLE
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    logic [7:0] dvd_r;
    logic [3:0] dvs_r;
    logic [3:0] partial;
    logic [2:0] cnt;
    logic [6:0] q_work;

    logic [7:0] a_mag;
    logic [3:0] b_mag;
    logic [4:0] p;
    logic       ge;
    logic [3:0] rem_next;
    logic [7:0] q_next;
    logic [7:0] q_final;
    logic [3:0] r_final;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // -128 maps to magnitude 128, which still fits the unsigned core
    always_comb begin
        a_mag = dividend[7] ? (~dividend + 8'd1) : dividend;
        b_mag = divisor[3]  ? (~divisor + 4'd1)  : divisor;
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    // The partial remainder is always below the divisor, so four stored bits suffice
    always_comb begin
        p        = {partial, dvd_r[7]};
        ge       = (p >= {1'b0, dvs_r});
        rem_next = ge ? 4'(p - {1'b0, dvs_r}) : p[3:0];
        q_next   = {q_work, ge};
`ifdef DIVIDER_SIGNED_EN
        q_final  = neg_q ? (~q_next + 8'd1) : q_next;
        r_final  = neg_r ? (~rem_next + 4'd1) : rem_next;
`else
        q_final  = q_next;
        r_final  = rem_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dvd_r     <= 8'h00;
            dvs_r     <= 4'h0;
            partial   <= 4'h0;
            cnt       <= 3'd0;
            q_work    <= 7'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= 8'h00;
            remainder <= 4'h0;
            div_zero  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        dvd_r   <= a_mag;
                        dvs_r   <= b_mag;
                        partial <= 4'h0;
                        cnt     <= 3'd0;
                        q_work  <= 7'h00;
`ifdef DIVIDER_SIGNED_EN
                        neg_q   <= dividend[7] ^ divisor[3];
                        neg_r   <= dividend[7];
`endif
                        if (divisor == 4'h0) begin
                            quotient  <= 8'hFF;
                            remainder <= dividend[3:0];
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            div_zero  <= 1'b0;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    partial <= rem_next;
                    q_work  <= q_next[6:0];
                    dvd_r   <= {dvd_r[6:0], 1'b0};
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        quotient  <= q_final;
                        remainder <= r_final;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8_4_bit_seq.sv
// Directed bench for divider_8_4_bit_seq: vector table plus handshake and reset sequences.
module tb_divider_8_4_bit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_total = 0;
    int n_pass  = 0;

    divider_8_4_bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_dz;
        int         exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Launch one operation from IDLE; lat counts edges after the accept edge until done is seen
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic dz, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 99;
        q = 8'h00; r = 4'h0; dz = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                lat = k;
                q   = quotient;
                r   = remainder;
                dz  = div_zero;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] gq;
    logic [3:0] gr;
    logic       gdz;
    int         glat;
    int         ndone;
    int         nbusy;
    int         acc[$];
    logic       prev_busy;

    initial begin
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 8});  // -100/7
        vecs.push_back('{8'h64, 4'h9, 8'hF2, 4'h2, 1'b0, 8});  // 100/-7
        vecs.push_back('{8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 8});  // -128/-1
        vecs.push_back('{8'd100, 4'd0, 8'hFF, 4'h4, 1'b1, 0});
        vecs.push_back('{8'd9,   4'd2, 8'd4,  4'd1, 1'b0, 8});
        vecs.push_back('{8'h9C, 4'h0, 8'hFF, 4'hC, 1'b1, 0});
        vecs.push_back('{8'd7,   4'd3, 8'd2,  4'd1, 1'b0, 8});
`else
        vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8});
        vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8});
        vecs.push_back('{8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 8});
        vecs.push_back('{8'd100, 4'd0,  8'hFF,  4'h4, 1'b1, 0});
        vecs.push_back('{8'd9,   4'd2,  8'd4,   4'd1, 1'b0, 8});
        vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8});
        vecs.push_back('{8'd7,   4'd9,  8'd0,   4'd7, 1'b0, 8});
        vecs.push_back('{8'd128, 4'd15, 8'd8,   4'd8, 1'b0, 8});
`endif

        // Reset with random inputs
        rst_n    = 1'b0;
        start    = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_zero", div_zero, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (busy || done) nbusy++;
        end
        chk("idle_no_activity", nbusy, 0);

        // Vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].dvd, vecs[i].dvs, gq, gr, gdz, glat);
            chk($sformatf("vec%0d_latency", i), glat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_quotient", i), gq, vecs[i].exp_q);
            chk($sformatf("vec%0d_remainder", i), gr, vecs[i].exp_r);
            chk($sformatf("vec%0d_div_zero", i), gdz, vecs[i].exp_dz);
        end
        chk("busy_after_ops", busy, 0);

        // Start while busy is ignored; operand changes mid-CALC have no effect
        ndone = 0;
        gq = 8'h00; gr = 4'h0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            case (c)
                0: begin start = 1'b1; dividend = 8'd50; divisor = 4'd3; end
                1: start = 1'b0;
                4: begin start = 1'b1; dividend = 8'd9; divisor = 4'd9; end
                5: begin start = 1'b0; dividend = 8'd255; divisor = 4'd1; end
                6: begin dividend = 8'd17; divisor = 4'd0; end
                default: ;
            endcase
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                gq = quotient;
                gr = remainder;
            end
        end
        chk("hs_done_count", ndone, 1);
        chk("hs_quotient", gq, 16);
        chk("hs_remainder", gr, 2);

        // Start held high: accepts every 10 cycles
        prev_busy = busy;
        ndone = 0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd20;
        divisor  = 4'd4;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) acc.push_back(c);
            if (done) ndone++;
            prev_busy = busy;
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_accept_count", acc.size(), 4);
        if (acc.size() >= 3) begin
            chk("held_spacing_1", acc[1] - acc[0], 10);
            chk("held_spacing_2", acc[2] - acc[1], 10);
        end
        chk("held_done_count", ndone, 3);
        for (int c = 0; c < 15 && busy; c++) @(posedge clk);
        #1;
        chk("held_idle_after", busy, 0);

        // Reset mid-CALC aborts
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op(8'd64, 4'd8, gq, gr, gdz, glat);
        chk("post_abort_latency", glat, 8);
`ifdef DIVIDER_SIGNED_EN
        chk("post_abort_quotient", gq, 8'hF8);
`else
        chk("post_abort_quotient", gq, 8);
`endif
        chk("post_abort_remainder", gr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
